dmem_access_ctrl: RTL and testbench

//  Load/store front end directly upstream of the byte-addressed data memory.
//  - Accepts one lb/lbu/lh/lhu/lw/sb/sh/sw request from the CPU core through a req/ready handshake.
//  - Checks alignment and range, translates the CPU byte address to the local memory address, and drives the memory port for exactly one cycle.
//  - Registers load data and returns a one-cycle done pulse, or flags an address-error exception with BadVAddr for CP0.

---
 rtl/cpu_defs.sv | 23 ++
 rtl/dmem_access_ctrl_if.sv | 27 ++
 rtl/dmem_addr_check.sv | 29 ++
 rtl/dmem_access_ctrl.sv | 115 +++++++++++
 tb/tb_dmem_access_ctrl.sv | 254 +++++++++++++++++++++++++
 5 files changed

// File: rtl/cpu_defs.sv
// Shared CPU-side definitions: access sizes, data-memory window, FSM states
// and address-error exception codes.
package cpu_defs;

   localparam logic [2:0]  SZ_B = 3'd1;
   localparam logic [2:0]  SZ_H = 3'd2;
   localparam logic [2:0]  SZ_W = 3'd4;

   localparam logic [31:0] DM_BASE  = 32'h1001_0000;
   localparam int unsigned DM_BYTES = 1024;
   localparam int unsigned DM_AW    = 11;

   localparam logic [4:0]  EXC_ADEL = 5'd4;
   localparam logic [4:0]  EXC_ADES = 5'd5;

   typedef enum logic [1:0] {
      ST_IDLE,
      ST_ACCESS,
      ST_DONE,
      ST_ERR
   } dm_state_t;

endpackage

// File: rtl/dmem_access_ctrl_if.sv
// CPU-side load/store request and response bundle for the data-memory front end.
interface dmem_access_ctrl_if;

   logic        req;
   logic        req_ready;
   logic        req_wr;
   logic [2:0]  req_size;
   logic        req_sign;
   logic [31:0] req_addr;
   logic [31:0] req_wdata;
   logic        done;
   logic [31:0] rdata;
   logic        addr_err;
   logic        err_store;
   logic [31:0] bad_vaddr;

   modport master (
      output req, req_wr, req_size, req_sign, req_addr, req_wdata,
      input  req_ready, done, rdata, addr_err, err_store, bad_vaddr
   );

   modport slave (
      input  req, req_wr, req_size, req_sign, req_addr, req_wdata,
      output req_ready, done, rdata, addr_err, err_store, bad_vaddr
   );

endinterface

// File: rtl/dmem_addr_check.sv
// Combinational size/alignment/range check and CPU-to-local offset translation
// for a memory window; shared with the instruction-fetch path.
module dmem_addr_check
   import cpu_defs::*;
#(
   parameter logic [31:0] DM_BASE  = cpu_defs::DM_BASE,
   parameter int unsigned DM_BYTES = cpu_defs::DM_BYTES
) (
   input  logic [31:0] addr,
   input  logic [2:0]  size,
   output logic [31:0] off,
   output logic        fault
);

   logic [32:0] end_off;
   logic        size_ok;
   logic        misaligned;

   always_comb begin
      // Wrap-around subtract: addresses below the base become huge offsets.
      off        = addr - DM_BASE;
      end_off    = {1'b0, off} + {30'b0, size};
      size_ok    = (size == SZ_B) || (size == SZ_H) || (size == SZ_W);
      misaligned = ((size == SZ_H) && addr[0]) ||
                   ((size == SZ_W) && (addr[1:0] != 2'b00));
      fault      = !size_ok || misaligned || (end_off > 33'(DM_BYTES));
   end

endmodule

// File: rtl/dmem_access_ctrl.sv
// Load/store front end for the byte-addressed data memory: one request at a
// time, single-cycle memory access, done pulse or address-error report.
module dmem_access_ctrl
   import cpu_defs::*;
#(
   parameter logic [31:0] DM_BASE  = cpu_defs::DM_BASE,
   parameter int unsigned DM_BYTES = cpu_defs::DM_BYTES,
   parameter int unsigned DM_AW    = cpu_defs::DM_AW
) (
   input  logic               clk,
   input  logic               rst,
   dmem_access_ctrl_if.slave  bus,
   output logic               dm_ena,
   output logic               dm_we,
   output logic [DM_AW-1:0]   dm_addr,
   output logic [31:0]        dm_wdata,
   output logic [2:0]         dm_data_w,
   output logic               dm_data_sign,
   input  logic [31:0]        dm_rdata
);

   dm_state_t          state, state_nxt;
   logic               r_wr;
   logic [2:0]         r_size;
   logic               r_sign;
   logic [31:0]        r_wdata;
   logic [DM_AW-1:0]   r_off;
   logic [31:0]        chk_off;
   logic               chk_fault;
   logic               accept;
   logic               unused_off_hi;

   dmem_addr_check #(
      .DM_BASE  (DM_BASE),
      .DM_BYTES (DM_BYTES)
   ) u_chk (
      .addr  (bus.req_addr),
      .size  (bus.req_size),
      .off   (chk_off),
      .fault (chk_fault)
   );

   // Range check already bounds the offset below DM_BYTES; high bits are dead.
   assign unused_off_hi = ^chk_off[31:DM_AW];
   assign accept        = (state == ST_IDLE) && bus.req;

   always_ff @(posedge clk) begin
      if (rst) begin
         state         <= ST_IDLE;
         r_wr          <= 1'b0;
         r_size        <= '0;
         r_sign        <= 1'b0;
         r_wdata       <= '0;
         r_off         <= '0;
         bus.rdata     <= '0;
         bus.bad_vaddr <= '0;
      end else begin
         state <= state_nxt;
         if (accept) begin
            r_wr    <= bus.req_wr;
            r_size  <= bus.req_size;
            r_sign  <= bus.req_sign;
            r_wdata <= bus.req_wdata;
            r_off   <= chk_off[DM_AW-1:0];
            // Captured at acceptance so it is already valid in the ERR cycle.
            if (chk_fault)
               bus.bad_vaddr <= bus.req_addr;
         end
         if ((state == ST_ACCESS) && !r_wr)
            bus.rdata <= dm_rdata;
      end
   end

   always_comb begin
      state_nxt     = state;
      bus.req_ready = 1'b0;
      bus.done      = 1'b0;
      bus.addr_err  = 1'b0;
      bus.err_store = 1'b0;
      dm_ena        = 1'b0;
      dm_we         = 1'b0;
      dm_addr       = '0;
      dm_wdata      = '0;
      dm_data_w     = '0;
      dm_data_sign  = 1'b0;
      case (state)
         ST_IDLE: begin
            bus.req_ready = 1'b1;
            if (bus.req)
               state_nxt = chk_fault ? ST_ERR : ST_ACCESS;
         end
         ST_ACCESS: begin
            // Gated by rst so a reset landing on this cycle cancels the write.
            dm_ena       = ~rst;
            dm_we        = r_wr & ~rst;
            dm_addr      = r_off;
            dm_wdata     = r_wdata;
            dm_data_w    = r_size;
            dm_data_sign = r_sign;
            state_nxt    = ST_DONE;
         end
         ST_DONE: begin
            bus.done  = 1'b1;
            state_nxt = ST_IDLE;
         end
         ST_ERR: begin
            bus.addr_err  = 1'b1;
            bus.err_store = r_wr;
            state_nxt     = ST_IDLE;
         end
         default: state_nxt = ST_IDLE;
      endcase
   end

endmodule

// File: tb/tb_dmem_access_ctrl.sv
// Randomized self-checking bench for dmem_access_ctrl with a byte-array
// memory and a transaction-level reference model.
module tb_dmem_access_ctrl;

   localparam logic [31:0] BASE  = 32'h1001_0000;
   localparam int          BYTES = 1024;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        dm_ena, dm_we, dm_data_sign;
   logic [10:0] dm_addr;
   logic [31:0] dm_wdata, dm_rdata, rd_tmp;
   logic [2:0]  dm_data_w;

   logic [7:0]  mem     [0:BYTES-1];
   logic [7:0]  ref_mem [0:BYTES-1];
   logic [31:0] exp_rdata = '0;
   logic [31:0] exp_bad   = '0;
   int          n_tests = 0;
   int          n_fail  = 0;
   bit          running = 1'b0;

   dmem_access_ctrl_if ifc ();

   dmem_access_ctrl #(
      .DM_BASE  (32'h1001_0000),
      .DM_BYTES (1024),
      .DM_AW    (11)
   ) dut (
      .clk          (clk),
      .rst          (rst),
      .bus          (ifc.slave),
      .dm_ena       (dm_ena),
      .dm_we        (dm_we),
      .dm_addr      (dm_addr),
      .dm_wdata     (dm_wdata),
      .dm_data_w    (dm_data_w),
      .dm_data_sign (dm_data_sign),
      .dm_rdata     (dm_rdata)
   );

   always #5 clk = ~clk;

   // Memory: little-endian bytes, write on the edge, read combinational and extended.
   always @(posedge clk)
      if (dm_ena && dm_we)
         for (int i = 0; i < 4; i++)
            if (i < int'(dm_data_w)) mem[(int'(dm_addr) + i) & (BYTES-1)] <= dm_wdata[8*i +: 8];

   always_comb begin
      rd_tmp = '0;
      for (int i = 0; i < 4; i++)
         if (i < int'(dm_data_w)) rd_tmp[8*i +: 8] = mem[(int'(dm_addr) + i) & (BYTES-1)];
      if (dm_data_sign && dm_data_w == 3'd1) rd_tmp = {{24{rd_tmp[7]}}, rd_tmp[7:0]};
      if (dm_data_sign && dm_data_w == 3'd2) rd_tmp = {{16{rd_tmp[15]}}, rd_tmp[15:0]};
      dm_rdata = rd_tmp;
   end

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_tests++;
      if (obs !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", tag, obs, exp, $time);
      end
   endtask

   always @(negedge clk)
      if (running) check("done_and_err", 32'(ifc.done & ifc.addr_err), 32'd0);

   function automatic bit ref_legal(input logic [2:0] size, input logic [31:0] addr);
      longint off;
      off = longint'(addr) - longint'(BASE);
      if (!(size == 3'd1 || size == 3'd2 || size == 3'd4)) return 1'b0;
      if ((addr % 32'(size)) != 0) return 1'b0;
      return (off >= 0) && (off + longint'(size) <= longint'(BYTES));
   endfunction

   function automatic logic [31:0] ref_load(input int off, input int size, input bit sgn);
      longint v;
      v = 0;
      for (int i = 0; i < size; i++) v += longint'(ref_mem[off + i]) << (8 * i);
      if (sgn && size < 4 && v >= (longint'(1) << (8 * size - 1))) v -= longint'(1) << (8 * size);
      return v[31:0];
   endfunction

   // Caller is at a negedge; returns at the negedge where the block is idle again.
   task automatic do_op(input logic wr, input logic [2:0] size, input logic sgn,
                        input logic [31:0] addr, input logic [31:0] wdata, input bit hold,
                        input logic b_wr, input logic [2:0] b_size, input logic b_sgn,
                        input logic [31:0] b_addr, input logic [31:0] b_wdata);
      int n;
      int off;
      n = 0;
      while (!ifc.req_ready && n < 20) begin
         @(negedge clk);
         n++;
      end
      check("ready_wait", 32'(ifc.req_ready), 32'd1);
      ifc.req = 1'b1; ifc.req_wr = wr; ifc.req_size = size; ifc.req_sign = sgn;
      ifc.req_addr = addr; ifc.req_wdata = wdata;
      off = int'(addr - BASE);
      @(negedge clk);
      if (hold) begin
         ifc.req_wr = b_wr; ifc.req_size = b_size; ifc.req_sign = b_sgn;
         ifc.req_addr = b_addr; ifc.req_wdata = b_wdata;
      end else begin
         ifc.req = 1'b0;
      end
      if (ref_legal(size, addr)) begin
         check("acc_ena", 32'(dm_ena), 32'd1);
         check("acc_we", 32'(dm_we), 32'(wr));
         check("acc_addr", 32'(dm_addr), 32'(off));
         check("acc_wdata", dm_wdata, wdata);
         check("acc_width", 32'(dm_data_w), 32'(size));
         check("acc_sign", 32'(dm_data_sign), 32'(sgn));
         check("acc_ready", 32'(ifc.req_ready), 32'd0);
         check("acc_done", 32'(ifc.done), 32'd0);
         if (wr) begin
            for (int i = 0; i < int'(size); i++) ref_mem[off + i] = wdata[8*i +: 8];
         end else begin
            exp_rdata = ref_load(off, int'(size), sgn);
         end
         @(negedge clk);
         check("done", 32'(ifc.done), 32'd1);
         check("done_err", 32'(ifc.addr_err), 32'd0);
         check("done_ena", 32'(dm_ena), 32'd0);
         check("rdata", ifc.rdata, exp_rdata);
         check("bad_held", ifc.bad_vaddr, exp_bad);
      end else begin
         exp_bad = addr;
         check("err", 32'(ifc.addr_err), 32'd1);
         check("err_store", 32'(ifc.err_store), 32'(wr));
         check("bad_vaddr", ifc.bad_vaddr, addr);
         check("err_ena", 32'(dm_ena), 32'd0);
         check("err_done", 32'(ifc.done), 32'd0);
         check("err_rdata", ifc.rdata, exp_rdata);
      end
      @(negedge clk);
      check("idle_ready", 32'(ifc.req_ready), 32'd1);
      check("idle_done", 32'(ifc.done), 32'd0);
      check("idle_err", 32'(ifc.addr_err), 32'd0);
      check("idle_ena", 32'(dm_ena), 32'd0);
   endtask

   task automatic op(input logic wr, input logic [2:0] size, input logic sgn,
                     input logic [31:0] addr, input logic [31:0] wdata);
      do_op(wr, size, sgn, addr, wdata, 1'b0, 1'b0, 3'd0, 1'b0, 32'd0, 32'd0);
   endtask

   task automatic check_quiet(input string pfx);
      check({pfx, "_ready"}, 32'(ifc.req_ready), 32'd1);
      check({pfx, "_done"}, 32'(ifc.done), 32'd0);
      check({pfx, "_err"}, 32'(ifc.addr_err), 32'd0);
      check({pfx, "_estore"}, 32'(ifc.err_store), 32'd0);
      check({pfx, "_rdata"}, ifc.rdata, 32'd0);
      check({pfx, "_bad"}, ifc.bad_vaddr, 32'd0);
      check({pfx, "_ena"}, 32'(dm_ena), 32'd0);
      check({pfx, "_we"}, 32'(dm_we), 32'd0);
      check({pfx, "_addr"}, 32'(dm_addr), 32'd0);
      check({pfx, "_wdata"}, dm_wdata, 32'd0);
      check({pfx, "_w"}, 32'(dm_data_w), 32'd0);
   endtask

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      logic [2:0]  sz;
      logic [31:0] a;
      int unsigned r;
      for (int i = 0; i < BYTES; i++) begin
         mem[i] = 8'h00;
         ref_mem[i] = 8'h00;
      end
      ifc.req = 1'b0; ifc.req_wr = 1'b0; ifc.req_size = '0; ifc.req_sign = 1'b0;
      ifc.req_addr = '0; ifc.req_wdata = '0;
      rst = 1'b1;
      repeat (3) @(negedge clk);
      rst = 1'b0;
      @(negedge clk);
      running = 1'b1;
      check_quiet("reset");

      op(1'b1, 3'd4, 1'b0, 32'h1001_0010, 32'hDEAD_BEEF);
      op(1'b0, 3'd4, 1'b0, 32'h1001_0010, 32'h0);
      check("t1_lw_const", ifc.rdata, 32'hDEAD_BEEF);

      op(1'b1, 3'd1, 1'b0, 32'h1001_0003, 32'h0000_0080);
      op(1'b0, 3'd1, 1'b1, 32'h1001_0003, 32'h0);
      check("t2_lb_const", ifc.rdata, 32'hFFFF_FF80);
      op(1'b0, 3'd1, 1'b0, 32'h1001_0003, 32'h0);
      check("t2_lbu_const", ifc.rdata, 32'h0000_0080);

      op(1'b0, 3'd2, 1'b0, 32'h1001_0001, 32'h0);
      check("t3_bad_const", ifc.bad_vaddr, 32'h1001_0001);
      op(1'b1, 3'd4, 1'b0, 32'h1001_0002, 32'h5555_AAAA);

      op(1'b0, 3'd4, 1'b0, 32'h1001_03FC, 32'h0);
      op(1'b0, 3'd4, 1'b0, 32'h1001_0400, 32'h0);
      op(1'b1, 3'd1, 1'b0, 32'h1000_FFFF, 32'h0000_0011);
      op(1'b0, 3'd3, 1'b0, 32'h1001_0010, 32'h0);
      op(1'b0, 3'd4, 1'b0, 32'h1001_03FE, 32'h0);

      do_op(1'b1, 3'd4, 1'b0, 32'h1001_0040, 32'h1111_2222, 1'b1,
            1'b0, 3'd4, 1'b0, 32'h1001_0040, 32'h0);
      op(1'b0, 3'd4, 1'b0, 32'h1001_0040, 32'h0);
      check("t5_bp_const", ifc.rdata, 32'h1111_2222);

      op(1'b1, 3'd4, 1'b0, 32'h1001_0020, 32'hCAFE_F00D);
      ifc.req = 1'b1; ifc.req_wr = 1'b1; ifc.req_size = 3'd4; ifc.req_sign = 1'b0;
      ifc.req_addr = 32'h1001_0020; ifc.req_wdata = 32'h1234_5678;
      @(negedge clk);
      ifc.req = 1'b0;
      check("t6_acc_ena", 32'(dm_ena), 32'd1);
      rst = 1'b1;
      #1;
      check("t6_rst_we", 32'(dm_we), 32'd0);
      check("t6_rst_ena", 32'(dm_ena), 32'd0);
      @(negedge clk);
      rst = 1'b0;
      exp_rdata = '0;
      exp_bad = '0;
      check_quiet("t6_after");
      @(negedge clk);
      check("t6_no_done", 32'(ifc.done), 32'd0);
      check("t6_no_err", 32'(ifc.addr_err), 32'd0);
      op(1'b0, 3'd4, 1'b0, 32'h1001_0020, 32'h0);
      check("t6_old_data", ifc.rdata, 32'hCAFE_F00D);

      for (int k = 0; k < 300; k++) begin
         case ($urandom_range(0, 9))
            0, 1, 2: sz = 3'd1;
            3, 4:    sz = 3'd2;
            5, 6, 7: sz = 3'd4;
            8:       sz = 3'd3;
            default: sz = 3'($urandom_range(0, 7));
         endcase
         r = $urandom_range(0, 15);
         if (r == 0)      a = $urandom;
         else if (r == 1) a = BASE - 32'($urandom_range(1, 8));
         else             a = BASE + 32'($urandom_range(0, 1030));
         if (r >= 2 && r < 13 && (sz == 3'd2 || sz == 3'd4)) a = a & ~(32'(sz) - 32'd1);
         op(1'($urandom_range(0, 1)), sz, 1'($urandom_range(0, 1)), a, $urandom);
      end

      running = 1'b0;
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
